// File: rtl/arbtst_pkg.sv
// Shared state encoding and width helper for the arbiter-test client.
package arbtst_pkg;

    localparam logic [2:0] ST_LOAD = 3'd0;
    localparam logic [2:0] ST_REQ  = 3'd1;
    localparam logic [2:0] ST_WAIT = 3'd2;
    localparam logic [2:0] ST_READ = 3'd3;
    localparam logic [2:0] ST_OUT  = 3'd4;

    typedef enum logic [2:0] {
        LOAD = ST_LOAD,
        REQ  = ST_REQ,
        WAIT = ST_WAIT,
        READ = ST_READ,
        OUT  = ST_OUT
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned maxv);
        return (maxv < 1) ? 1 : $clog2(maxv + 1);
    endfunction

endpackage

// File: rtl/arbtst_down_cnt.sv
// Loadable saturating down-counter with a zero flag.
module arbtst_down_cnt
    import arbtst_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/arbtst_client_n.sv
// Arbiter-test client: request, present operands, loop result PASSES times.
// Grant timeout is built only with ARBTST_CLIENT_TMO_EN defined.
module arbtst_client_n
    import arbtst_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned PASSES  = 1,
    parameter int unsigned RES_LAT = 1,
    parameter int unsigned TMO     = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ain,
    input  logic [WIDTH-1:0] bin,
    input  logic             gnt,
    input  logic [WIDTH-1:0] yin,
    output logic             req,
    output logic [WIDTH-1:0] aout,
    output logic [WIDTH-1:0] bout,
    output logic [WIDTH-1:0] yout,
    output logic             yvalid,
    output logic             err
);

    localparam int unsigned PW   = cnt_w(PASSES - 1);
    localparam int unsigned LMAX = (RES_LAT > 0) ? RES_LAT - 1 : 0;
    localparam int unsigned LW   = cnt_w(LMAX);
    localparam logic [PW-1:0] P_INIT = PW'(PASSES - 1);
    localparam logic [LW-1:0] L_INIT = LW'(LMAX);

    state_t state, nxt;
    logic [WIDTH-1:0] areg, breg;
    logic pass_ld, pass_dec, pass_zero;
    logic lat_ld, lat_dec, lat_zero;
    logic tmo_fire, tmo_flag;

    arbtst_down_cnt #(.W(PW)) u_pass (
        .clk      (clk),
        .reset    (reset),
        .load     (pass_ld),
        .load_val (P_INIT),
        .dec      (pass_dec),
        .zero     (pass_zero)
    );

    arbtst_down_cnt #(.W(LW)) u_lat (
        .clk      (clk),
        .reset    (reset),
        .load     (lat_ld),
        .load_val (L_INIT),
        .dec      (lat_dec),
        .zero     (lat_zero)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            areg  <= '0;
            breg  <= '0;
        end else begin
            state <= nxt;
            if (state == LOAD) begin
                areg <= ain;
                breg <= bin;
            end else if (state == READ) begin
                areg <= yin;
            end
        end
    end

    always_comb begin
        nxt      = state;
        req      = 1'b0;
        aout     = '0;
        bout     = '0;
        yout     = '0;
        yvalid   = 1'b0;
        pass_ld  = 1'b0;
        pass_dec = 1'b0;
        lat_ld   = 1'b0;
        lat_dec  = 1'b0;
        unique case (state)
            LOAD: begin
                pass_ld = 1'b1;
                nxt     = REQ;
            end
            REQ: begin
                req  = 1'b1;
                aout = areg;
                bout = breg;
                if (gnt) begin
                    lat_ld = 1'b1;
                    if (RES_LAT == 0) nxt = READ;
                    else              nxt = WAIT;
                end else if (tmo_fire) begin
                    nxt = OUT;
                end
            end
            WAIT: begin
                req     = 1'b1;
                aout    = areg;
                bout    = breg;
                lat_dec = 1'b1;
                if (lat_zero) nxt = READ;
            end
            READ: begin
                aout = areg;
                bout = breg;
                if (!pass_zero) begin
                    pass_dec = 1'b1;
                    nxt      = REQ;
                end else begin
                    nxt = OUT;
                end
            end
            OUT: begin
                yout   = areg;
                yvalid = !tmo_flag;
                nxt    = LOAD;
            end
            default: nxt = LOAD;
        endcase
    end

`ifdef ARBTST_CLIENT_TMO_EN
    localparam int unsigned TW = cnt_w((TMO > 0) ? TMO - 1 : 0);
    localparam logic [TW-1:0] T_INIT = TW'((TMO > 0) ? TMO - 1 : 0);

    logic tmo_ld, tmo_dec, tmo_zero;

    // Reload on every entry to REQ so each pass gets a full window.
    assign tmo_ld  = (nxt == REQ) && (state != REQ);
    assign tmo_dec = (state == REQ) && !gnt;

    arbtst_down_cnt #(.W(TW)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (tmo_ld),
        .load_val (T_INIT),
        .dec      (tmo_dec),
        .zero     (tmo_zero)
    );

    assign tmo_fire = tmo_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_flag <= 1'b0;
        end else begin
            tmo_flag <= (state == REQ) && !gnt && tmo_zero;
        end
    end

    assign err = (state == OUT) && tmo_flag;
`else
    localparam bit TMO_ON = (TMO > 0);

    assign tmo_fire = 1'b0;
    assign tmo_flag = 1'b0;
    assign err      = TMO_ON & 1'b0;
`endif

endmodule

// File: doc/arbtst_client_n.md
# arbtst_client_n

Parametrised arbiter-test client. It captures an operand pair, requests a shared resource through the arbiter, and presents operands while granted. It reads back the result and loops that result through the resource a configurable number of times before emitting it. It sits alongside other clients on a shared arbiter/resource port in the arbitration testbench, and adds a real grant handshake and a fixed resource latency.

## Interface
- WIDTH, 4, data width of operands and result
- PASSES, 1, round trips through the shared resource per operand pair (>=1)
- RES_LAT, 1, cycles from grant-sampled to result-valid on yin (>=0)
- TMO, 15, grant timeout in cycles (used only with ARBTST_CLIENT_TMO_EN)
- clk  input  1  clock, all state on posedge
- reset  input  1  asynchronous, active-low
- ain  input  WIDTH  operand A from stimulus
- bin  input  WIDTH  operand B from stimulus
- gnt  input  1  arbiter grant for this client
- yin  input  WIDTH  result from shared resource
- req  output  1  arbiter request
- aout  output  WIDTH  operand A to shared resource
- bout  output  WIDTH  operand B to shared resource
- yout  output  WIDTH  final result
- yvalid  output  1  one-cycle pulse, yout valid
- err  output  1  one-cycle pulse, grant timeout (tied 0 without the macro)

## Operation
- Registers: areg, breg (WIDTH), pass_cnt, lat_cnt, tmo_cnt, and the state.
- Reset (reset=0, async) puts the block in LOAD with areg=breg=0 and all counters 0.
- All outputs are 0 during reset and whenever the block is not driving them.
- LOAD: on the edge, areg<=ain, breg<=bin, pass_cnt<=PASSES-1, then go to REQ.
- REQ: req=1, aout=areg, bout=breg.
  - On an edge where gnt=1: lat_cnt<=RES_LAT-1, then go to WAIT.
  - If RES_LAT=0, go straight to READ instead.
  - While gnt=0, stay in REQ.
- WAIT: req=1, aout=areg, bout=breg. Decrement lat_cnt. Go to READ on the edge where lat_cnt=0.
- READ: req=0, aout/bout still driven. On the edge, areg<=yin.
  - If pass_cnt!=0: pass_cnt<=pass_cnt-1, go to REQ.
  - Otherwise go to OUT.
- OUT: yout=areg, yvalid=1, then go to LOAD.
- breg is constant across all passes of one operand pair.
- gnt is ignored outside REQ. A gnt that stays high from an earlier pass is honoured at the first REQ cycle.
- No arithmetic in the block; operands and results pass through at WIDTH bits.
- Counter widths are $clog2(max value + 1), minimum 1 bit.

## Timing
- With gnt already high when REQ is entered, latency from LOAD to the yvalid cycle is 1 + PASSES*(RES_LAT+2) cycles.
  - PASSES=1, RES_LAT=1: LOAD, REQ, WAIT, READ, OUT. yvalid is in cycle 5 counted from LOAD = cycle 1.
- Each extra cycle of gnt low in REQ adds exactly one cycle.
- req drops for at least one cycle (READ) between passes, so the arbiter can re-arbitrate.
- yvalid and err are single-cycle pulses in OUT. The next LOAD follows immediately.
- Reset asserted mid-operation aborts the current pair. No yvalid pulse is produced for it, and the block restarts in LOAD after reset deasserts.

## Configuration
- ARBTST_CLIENT_TMO_EN defined:
  - tmo_cnt counts cycles in REQ with gnt=0 and clears on entry to REQ.
  - When tmo_cnt reaches TMO-1 with gnt still 0, go to OUT with yout=areg (current partial result), yvalid=0, err=1.
  - gnt=1 in the same cycle as the timeout takes priority; no error.
- ARBTST_CLIENT_TMO_EN undefined: there is no tmo_cnt, REQ waits indefinitely, and err is constant 0.

## Structure
- Package arbtst_pkg holds:
  - the state encoding localparams (LOAD, REQ, WAIT, READ, OUT);
  - a shared clog2-width helper function.
- One sub-module, arbtst_down_cnt: a loadable down-counter with a zero flag, parametrised by width. It is instantiated for lat_cnt, pass_cnt and (under the macro) tmo_cnt.
- The FSM and data registers stay in the top module.

## Test plan
- WIDTH=4, PASSES=1, RES_LAT=1, gnt tied 1:
  - stimulus ain=3, bin=5, resource returns yin=8;
  - required: yout=8 with yvalid exactly in cycle 5 after LOAD, and req high in REQ/WAIT only.
- PASSES=3, RES_LAT=0, resource computes a+b, ain=1, bin=2:
  - required: yout=7, with req low for one cycle between the three requests.
- gnt held 0 for 6 cycles in REQ:
  - required: yvalid is delayed by exactly 6 cycles;
  - required: aout/bout stay stable at areg/breg throughout.
- reset pulsed low during WAIT:
  - required: all outputs are 0 immediately, no yvalid pulse appears, and the next pair completes normally.
- ARBTST_CLIENT_TMO_EN, TMO=4, gnt never asserted:
  - required: err pulses in the cycle after REQ lasts 4 cycles, and yvalid stays 0.
- ARBTST_CLIENT_TMO_EN, TMO=4, gnt rising in the 4th REQ cycle:
  - required: no err, and normal completion.
